// File: rtl/bus_micro_sequencer_if.sv
// Control bundle between the microsequencer and the 4-bit shared-bus datapath.
interface bus_micro_sequencer_if #(
    parameter int unsigned DATA_W = 4
);
    // Instruction source / operator controls
    logic              single;
    logic              execute;
    logic              is_rom_done;
    logic [7:0]        opcode;

    // Datapath strobes
    logic [3:0]        reg_in;
    logic [3:0]        reg_out;
    logic [3:0]        reg_enable;
    logic [DATA_W-1:0] data_out;
    logic              data_ctrl;
    logic [1:0]        alu_ctrl;
    logic              rx_in_tri;
    logic              ry_in_tri;
    logic              rx_enable;
    logic              ry_enable;
    logic              alu_out;
    logic              store_in;
    logic              store_enable;

    // Status
    logic              done;
    logic              busy;
    logic              halted;

    // Sequencer side: consumes instructions, drives strobes
    modport master (
        input  single, execute, is_rom_done, opcode,
        output reg_in, reg_out, reg_enable, data_out, data_ctrl, alu_ctrl,
               rx_in_tri, ry_in_tri, rx_enable, ry_enable, alu_out,
               store_in, store_enable, done, busy, halted
    );

    // Datapath / environment side
    modport slave (
        output single, execute, is_rom_done, opcode,
        input  reg_in, reg_out, reg_enable, data_out, data_ctrl, alu_ctrl,
               rx_in_tri, ry_in_tri, rx_enable, ry_enable, alu_out,
               store_in, store_enable, done, busy, halted
    );
endinterface

// File: rtl/bus_micro_sequencer.sv
// Microsequencer: decodes one 8-bit instruction into per-cycle bus strobes,
// guaranteeing a single bus driver per cycle, and pulses done on retire.
// Strobes are registered from the next-state decode so they line up with
// the state they belong to while coming straight out of flops.
module bus_micro_sequencer #(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bus_micro_sequencer_if.master   bus
);
    localparam int unsigned REG_N = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] CLS_LOAD  = 2'b00;
    localparam logic [1:0] CLS_MOVE  = 2'b01;
    localparam logic [1:0] CLS_ALU   = 2'b10;
    localparam logic [1:0] CLS_STORE = 2'b11;

    state_t                  state, state_nx;
    logic [7:0]              ir, ir_nx;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    exec_q;
    logic                    exec_rise;
    logic                    start;

    logic [REG_N-1:0]        d_hot, s_hot;
    logic [REG_N-1:0]        reg_in_nx, reg_out_nx, reg_enable_nx;
    logic [DATA_W-1:0]       data_out_nx;
    logic                    data_ctrl_nx;
    logic [1:0]              alu_ctrl_nx;
    logic                    rx_in_tri_nx, ry_in_tri_nx, rx_enable_nx, ry_enable_nx;
    logic                    alu_out_nx, store_in_nx, store_enable_nx;
    logic                    done_nx, busy_nx, halted_nx;

    // Button synchroniser plus one delay flop for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            exec_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.execute};
            exec_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign exec_rise = sync_q[SYNC_STAGES-1] & ~exec_q;

    // Next state and instruction latch; mode inputs only matter in IDLE
    always_comb begin
        state_nx = state;
        ir_nx    = ir;
        start    = 1'b0;
        unique case (state)
            S_IDLE: begin
                start = bus.single ? exec_rise : ~bus.is_rom_done;
                if (start) begin
                    ir_nx    = bus.opcode;
                    state_nx = S_T1;
                end
            end
            S_T1:    state_nx = (ir[7:6] == CLS_ALU) ? S_T2 : S_DONE;
            S_T2:    state_nx = S_T3;
            S_T3:    state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Strobe decode for the upcoming state; IDLE and DONE leave everything low
    always_comb begin
        d_hot           = REG_N'(4'b0001 << ir_nx[5:4]);
        s_hot           = REG_N'(4'b0001 << ir_nx[3:2]);
        reg_in_nx       = '0;
        reg_out_nx      = '0;
        reg_enable_nx   = '0;
        data_out_nx     = '0;
        data_ctrl_nx    = 1'b0;
        alu_ctrl_nx     = 2'b00;
        rx_in_tri_nx    = 1'b0;
        ry_in_tri_nx    = 1'b0;
        rx_enable_nx    = 1'b0;
        ry_enable_nx    = 1'b0;
        alu_out_nx      = 1'b0;
        store_in_nx     = 1'b0;
        store_enable_nx = 1'b0;
        done_nx         = (state_nx == S_DONE);
        busy_nx         = (state_nx != S_IDLE);
        halted_nx       = (state_nx == S_IDLE) & ~bus.single & bus.is_rom_done;
        unique case (state_nx)
            S_T1: begin
                unique case (ir_nx[7:6])
                    CLS_LOAD: begin
                        data_ctrl_nx  = 1'b1;
                        data_out_nx   = DATA_W'(ir_nx[3:0]);
                        reg_in_nx     = d_hot;
                        reg_enable_nx = d_hot;
                    end
                    CLS_MOVE: begin
                        reg_out_nx    = s_hot;
                        reg_in_nx     = d_hot;
                        reg_enable_nx = d_hot;
                    end
                    CLS_ALU: begin
                        reg_out_nx   = d_hot;
                        rx_in_tri_nx = 1'b1;
                        rx_enable_nx = 1'b1;
                    end
                    CLS_STORE: begin
                        reg_out_nx      = d_hot;
                        store_in_nx     = 1'b1;
                        store_enable_nx = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T2: begin
                reg_out_nx   = s_hot;
                ry_in_tri_nx = 1'b1;
                ry_enable_nx = 1'b1;
            end
            S_T3: begin
                alu_out_nx    = 1'b1;
                alu_ctrl_nx   = ir_nx[1:0];
                reg_in_nx     = d_hot;
                reg_enable_nx = d_hot;
            end
            default: ;
        endcase
    end

    // State, instruction and registered strobes; reset drops strobes at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            ir               <= '0;
            bus.reg_in       <= '0;
            bus.reg_out      <= '0;
            bus.reg_enable   <= '0;
            bus.data_out     <= '0;
            bus.data_ctrl    <= 1'b0;
            bus.alu_ctrl     <= 2'b00;
            bus.rx_in_tri    <= 1'b0;
            bus.ry_in_tri    <= 1'b0;
            bus.rx_enable    <= 1'b0;
            bus.ry_enable    <= 1'b0;
            bus.alu_out      <= 1'b0;
            bus.store_in     <= 1'b0;
            bus.store_enable <= 1'b0;
            bus.done         <= 1'b0;
            bus.busy         <= 1'b0;
            bus.halted       <= 1'b0;
        end else begin
            state            <= state_nx;
            ir               <= ir_nx;
            bus.reg_in       <= reg_in_nx;
            bus.reg_out      <= reg_out_nx;
            bus.reg_enable   <= reg_enable_nx;
            bus.data_out     <= data_out_nx;
            bus.data_ctrl    <= data_ctrl_nx;
            bus.alu_ctrl     <= alu_ctrl_nx;
            bus.rx_in_tri    <= rx_in_tri_nx;
            bus.ry_in_tri    <= ry_in_tri_nx;
            bus.rx_enable    <= rx_enable_nx;
            bus.ry_enable    <= ry_enable_nx;
            bus.alu_out      <= alu_out_nx;
            bus.store_in     <= store_in_nx;
            bus.store_enable <= store_enable_nx;
            bus.done         <= done_nx;
            bus.busy         <= busy_nx;
            bus.halted       <= halted_nx;
        end
    end
endmodule
